register_file_scoreboard: RTL

Two-read/one-write architectural register file that supplies the In1/In2 operands of the ALU in the execute path. Also holds a per-register scoreboard of pending writes. It raises Stall when an operand is still being produced by an in-flight instruction, so the issue logic holds until the operand is valid. Writeback from the ALU Out path returns here through the write port.

---
 rtl/register_file_scoreboard.sv | 98 +++++++++
 1 files changed

// File: rtl/register_file_scoreboard.sv
// ============================================================================
// Module   : register_file_scoreboard
// Brief    : 2R/1W architectural register file with a per-register pending-
//            write scoreboard that raises Stall on operand hazards.
//            Optional macro RF_BYPASS_EN enables write-through read bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module register_file_scoreboard #(
  parameter  int REG_COUNT = 32,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RdEn1,
  input  logic [ADDR_W-1:0]     RdAddr1,
  output logic [`WORD_SIZE-1:0] RdData1,
  input  logic                  RdEn2,
  input  logic [ADDR_W-1:0]     RdAddr2,
  output logic [`WORD_SIZE-1:0] RdData2,
  input  logic                  WrEn,
  input  logic [ADDR_W-1:0]     WrAddr,
  input  logic [`WORD_SIZE-1:0] WrData,
  input  logic                  Issue,
  input  logic [ADDR_W-1:0]     IssueAddr,
  output logic                  Stall,
  output logic [REG_COUNT-1:0]  BusyVec
);

  logic [`WORD_SIZE-1:0] regs_q [REG_COUNT];
  logic [`WORD_SIZE-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  busy_d;

  logic byp1;
  logic byp2;
  logic haz1;
  logic haz2;

`ifdef RF_BYPASS_EN
  // Write-through: the value being written back is visible to readers this cycle.
  assign byp1 = WrEn && (WrAddr == RdAddr1) && (RdAddr1 != '0);
  assign byp2 = WrEn && (WrAddr == RdAddr2) && (RdAddr2 != '0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign haz1  = RdEn1 && busy_q[RdAddr1] && (RdAddr1 != '0) && !byp1;
  assign haz2  = RdEn2 && busy_q[RdAddr2] && (RdAddr2 != '0) && !byp2;
  assign Stall = !Rst && (haz1 || haz2);

  always_comb begin
    RdData1 = '0;
    RdData2 = '0;
    if (!Rst) begin
      if (byp1)                RdData1 = WrData;
      else if (RdAddr1 != '0)  RdData1 = regs_q[RdAddr1];
      if (byp2)                RdData2 = WrData;
      else if (RdAddr2 != '0)  RdData2 = regs_q[RdAddr2];
    end
  end

  // Issue set is applied after writeback clear so the newer producer wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (WrEn && (WrAddr != '0)) begin
      regs_d[WrAddr] = WrData;
      busy_d[WrAddr] = 1'b0;
    end
    if (Issue && !Stall && (IssueAddr != '0)) begin
      busy_d[IssueAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign BusyVec = busy_q;

endmodule

`default_nettype wire
